// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding RAM access initiator (MAR/MDR), address/data set up one cycle before any strobe.
// Latency: req edge to done = WAIT_CYCLES+2 cycles; out-of-range = 1 cycle when MEM_ACCESS_CTRL_BOUNDS_CHECK_EN is defined.
// Backpressure: none queued; req is sampled only in IDLE, and a req seen while busy is dropped.
`timescale 1ns/1ps
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WORDS  = 512
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);
    localparam int            CW       = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
        $error("mem_access_ctrl: WAIT_CYCLES must be at least 1");
    end
    if (ADDR_WORDS < 1) begin : g_bad_addr_words
        $error("mem_access_ctrl: ADDR_WORDS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mar_q, mar_d;
    logic [31:0]   wbuf_q, wbuf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          addr_oob;

`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);
    assign addr_oob = (addr_in >= ADDR_LIMIT);
`else
    assign addr_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    mar_d   = addr_in;
                    wbuf_d  = wdata;
                    op_d    = we;
                    err_d   = addr_oob;
                    state_d = addr_oob ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    if (!op_q) begin
                        rdata_d = mem_data_out;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight from a flop.
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        mem_read_d  = (state_d == S_ACCESS) && !op_d;
        mem_write_d = (state_d == S_ACCESS) && op_d;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q     <= S_IDLE;
            op_q        <= 1'b0;
            cnt_q       <= '0;
            mar_q       <= '0;
            wbuf_q      <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            mar_q       <= mar_d;
            wbuf_q      <= wbuf_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign mem_address = mar_q;
    assign mem_data_in = wbuf_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transaction-timeline model of the controller and a word RAM.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    localparam int WC = 3;
    localparam int AW = 512;

    logic        clock = 1'b0;
    logic        clear;
    logic        req, we;
    logic [31:0] addr_in, wdata;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] rdata, mem_address, mem_data_in, mem_data_out;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 clock = ~clock;

    mem_access_ctrl #(.WAIT_CYCLES(WC), .ADDR_WORDS(AW)) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .we          (we),
        .addr_in     (addr_in),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .mem_address (mem_address),
        .mem_data_in (mem_data_in),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_data_out(mem_data_out)
    );

    // Word RAM seen by the DUT: combinational read, written at each clock edge while strobed.
    bit [31:0] ram [0:AW-1];
    assign mem_data_out = ram[mem_address[8:0]];
    always @(posedge clock) begin
        if (mem_write) ram[mem_address[8:0]] <= mem_data_in;
    end

    // Reference model: k is the cycle index since acceptance (0 = idle), len the transaction length.
    int        k = 0, len = 0;
    bit        m_op, m_oob, m_err;
    bit [31:0] m_addr, m_wd, m_rd;
    bit [31:0] mram [0:AW-1];

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            k = 0; len = 0; m_op = 0; m_oob = 0; m_err = 0;
            m_addr = 0; m_wd = 0; m_rd = 0;
        end else if (k == 0) begin
            if (req) begin
                m_addr = addr_in;
                m_wd   = wdata;
                m_op   = we;
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
                m_oob  = (addr_in >= AW);
`else
                m_oob  = 1'b0;
`endif
                m_err  = m_oob;
                len    = m_oob ? 1 : WC + 2;
                k      = 1;
            end
        end else begin
            if (!m_oob && k >= 2 && k <= WC + 1) begin
                if (m_op) mram[m_addr[8:0]] = m_wd;
                else if (k == WC + 1) m_rd = mram[m_addr[8:0]];
            end
            k = (k == len) ? 0 : k + 1;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            chk1 ("busy",        busy,        k != 0);
            chk1 ("done",        done,        k != 0 && k == len);
            chk1 ("err",         err,         m_err);
            chk1 ("mem_read",    mem_read,    !m_oob && k >= 2 && k <= WC + 1 && !m_op);
            chk1 ("mem_write",   mem_write,   !m_oob && k >= 2 && k <= WC + 1 && m_op);
            chk32("rdata",       rdata,       m_rd);
            chk32("mem_address", mem_address, m_addr);
            chk32("mem_data_in", mem_data_in, m_wd);
        end
    end

    // Called at a falling edge with the DUT idle; returns at the falling edge of cycle 1.
    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; addr_in = a; wdata = d;
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic observe(input int n, output int da, output int nd, output int nr, output int nw,
                           output logic [31:0] rd_done, output logic err_done);
        da = -1; nd = 0; nr = 0; nw = 0; rd_done = '0; err_done = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (done) begin
                nd++;
                if (da < 0) begin
                    da = c; rd_done = rdata; err_done = err;
                end
            end
            if (mem_read) nr++;
            if (mem_write) nw++;
            @(negedge clock);
        end
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        int          da, nd, nr, nw;
        logic [31:0] rdd;
        logic        errd;
        int          dtimes[$];

        clear = 1'b1; req = 1'b0; we = 1'b0; addr_in = '0; wdata = '0;
        repeat (2) @(negedge clock);
        chk1 ("reset_busy", busy, 1'b0);
        chk1 ("reset_done", done, 1'b0);
        chk1 ("reset_err", err, 1'b0);
        chk1 ("reset_mem_read", mem_read, 1'b0);
        chk1 ("reset_mem_write", mem_write, 1'b0);
        chk32("reset_rdata", rdata, 32'h0);
        chk32("reset_mem_address", mem_address, 32'h0);
        chk32("reset_mem_data_in", mem_data_in, 32'h0);
        clear = 1'b0;
        cmp_en = 1'b1;
        @(negedge clock);

        // Write then read back 0x26.
        start(1'b1, 32'h26, 32'hDEADBEEF);
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk32("wr_done_cycle", 32'(da), 32'(WC + 2));
        chk32("wr_strobe_cycles", 32'(nw), 32'(WC));
        chk32("wr_no_read_strobe", 32'(nr), 32'd0);
        chk32("wr_leaves_rdata", rdd, 32'h0);
        start(1'b0, 32'h26, 32'h0);
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk32("rd_done_cycle", 32'(da), 32'(WC + 2));
        chk32("rd_strobe_cycles", 32'(nr), 32'(WC));
        chk32("rd_data_26", rdd, 32'hDEADBEEF);

        // Stretched read of a preloaded word.
        start(1'b1, 32'h5F, 32'hD);
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        start(1'b0, 32'h5F, 32'h0);
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk32("rd_data_5f", rdd, 32'hD);
        chk32("rd_5f_strobe_cycles", 32'(nr), 32'(WC));
        chk32("rd_5f_done_cycle", 32'(da), 32'(WC + 2));

        // Out-of-range read of 0x200.
        start(1'b0, 32'h200, 32'h0);
`ifdef MEM_ACCESS_CTRL_BOUNDS_CHECK_EN
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk32("oob_done_cycle", 32'(da), 32'd1);
        chk32("oob_no_strobe", 32'(nr + nw), 32'd0);
        chk1 ("oob_err", errd, 1'b1);
        chk32("oob_rdata_kept", rdd, 32'hD);
        chk1 ("oob_err_held", err, 1'b1);
        start(1'b0, 32'h1, 32'h0);
        chk1 ("inrange_clears_err", err, 1'b0);
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk1 ("inrange_err_at_done", errd, 1'b0);
`else
        observe(WC + 4, da, nd, nr, nw, rdd, errd);
        chk32("nochk_read_strobes", 32'(nr), 32'(WC));
        chk1 ("nochk_err", errd, 1'b0);
`endif

        // Request pulsed during ACCESS must be dropped.
        start(1'b0, 32'h26, 32'h0);
        @(negedge clock);
        req = 1'b1; we = 1'b1; addr_in = 32'h33;
        @(negedge clock);
        req = 1'b0;
        observe(WC + 3, da, nd, nr, nw, rdd, errd);
        chk32("ign_done_pulses", 32'(nd), 32'd1);
        chk32("ign_remaining_reads", 32'(nr), 32'(WC - 1));
        chk32("ign_no_write", 32'(nw), 32'd0);
        chk32("ign_mem_address", mem_address, 32'h26);

        // Clear in the middle of a write access.
        start(1'b1, 32'h10, 32'h12345678);
        @(negedge clock);
        chk1("pre_clear_mem_write", mem_write, 1'b1);
        #2 clear = 1'b1;
        #1;
        chk1 ("clr_mem_write", mem_write, 1'b0);
        chk1 ("clr_busy", busy, 1'b0);
        chk1 ("clr_done", done, 1'b0);
        chk32("clr_mem_address", mem_address, 32'h0);
        chk32("clr_mem_data_in", mem_data_in, 32'h0);
        chk32("clr_rdata", rdata, 32'h0);
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // Back-to-back: req held high, direction flipped after each completion.
        req = 1'b1; we = 1'b1; addr_in = 32'h40; wdata = 32'hCAFE0001;
        for (int c = 1; c <= 4 * (WC + 3); c++) begin
            @(negedge clock);
            if (done) begin
                dtimes.push_back(c);
                we = ~we;
                wdata = $urandom;
            end
        end
        req = 1'b0;
        chk32("b2b_done_count", 32'(dtimes.size()), 32'd4);
        if (dtimes.size() > 0) chk32("b2b_first_done", 32'(dtimes[0]), 32'(WC + 2));
        for (int i = 1; i < dtimes.size(); i++)
            chk32("b2b_spacing", 32'(dtimes[i] - dtimes[i-1]), 32'(WC + 3));
        repeat (WC + 4) @(negedge clock);

        // Randomized traffic, including in- and out-of-range addresses and rare clears.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            req = ($urandom_range(0, 2) == 0);
            we  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       addr_in = $urandom_range(0, 15);
                1:       addr_in = $urandom_range(500, 530);
                2:       addr_in = $urandom;
                default: addr_in = $urandom_range(0, AW - 1);
            endcase
            wdata = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #1 clear = 1'b1;
                #2 clear = 1'b0;
            end
        end
        req = 1'b0;
        repeat (WC + 4) @(negedge clock);
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access initiator for the CPU datapath. It accepts one read or write request at a time from the control unit, latches the address into an internal MAR and the write data into an internal MDR, and drives the word-addressed, level-sensitive RAM port. On reads it captures the RAM output into the MDR. Address and data are set up one cycle before any strobe is raised, so the combinational RAM never sees a strobe with unstable inputs.

## Interface
Parameters:
- WAIT_CYCLES, 1, cycles the read/write strobe is held (legal range ≥1)
- ADDR_WORDS, 512, number of implemented RAM words (used by bounds check)

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- req  in  1  access request, sampled in IDLE only
- we  in  1  1 = write, 0 = read; sampled with req
- addr_in  in  32  word address; sampled with req
- wdata  in  32  write data; sampled with req
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  out-of-range flag (see Configuration)
- rdata  out  32  MDR contents
- mem_address  out  32  to RAM address (MAR)
- mem_data_in  out  32  to RAM data_in
- mem_read  out  1  to RAM read
- mem_write  out  1  to RAM write
- mem_data_out  in  32  from RAM data_out

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: when req=1, latch addr_in→MAR, wdata→wbuf, we→op; go to SETUP. When req=0, stay.
- SETUP: MAR and wbuf are driven; mem_read=mem_write=0. Load wait counter with WAIT_CYCLES-1; go to ACCESS.
- ACCESS: mem_write=op, mem_read=!op. Decrement the counter each cycle. When the counter is 0: if read, rdata←mem_data_out; go to DONE.
- DONE: strobes are 0 and done=1; go to IDLE.
- mem_read and mem_write are never high together and are never high outside ACCESS.
- req in SETUP, ACCESS or DONE is ignored. It is not queued.
- mem_address and mem_data_in hold their latched values until the next accepted request.
- rdata is changed only by a completed read (or by clear). Writes leave rdata unchanged.
- Reset values: state=IDLE, busy=0, done=0, err=0, rdata=0, mem_address=0, mem_data_in=0, mem_read=0, mem_write=0, counter=0.
- clear during any state: strobes drop immediately (asynchronously) and all registers take their reset values. An in-flight write may be partial; this is the caller's responsibility.

## Timing
- Request sampled at edge 0. SETUP runs in cycle 1. ACCESS runs in cycles 2 … 1+WAIT_CYCLES. DONE runs in cycle 2+WAIT_CYCLES.
- Latency from req edge to done high = WAIT_CYCLES+2 cycles. With the default this is 3.
- Read data is visible on rdata from the DONE cycle onward.
- Minimum request spacing = WAIT_CYCLES+3 cycles, because IDLE is always visited.
- busy rises in the cycle after req is accepted and falls in the cycle after DONE.
- All outputs are registered. No combinational path exists from req or mem_data_out to any output.

## Configuration
- MEM_ACCESS_CTRL_BOUNDS_CHECK_EN defined:
  - If a request is accepted with addr_in ≥ ADDR_WORDS, the controller goes IDLE→DONE directly and never asserts any strobe.
  - err=1 from the DONE cycle until the next accepted request; rdata is unchanged.
  - Latency is 1 cycle.
  - An in-range request clears err at acceptance.
- Not defined:
  - No check is made; every address goes through SETUP/ACCESS.
  - err is tied to 0.

## Test plan
- Reset mid-ACCESS: write to 0x10, assert clear in cycle 2 → mem_write drops without a clock edge; all outputs return to 0; state is IDLE.
- Write then read, WAIT_CYCLES=1: write 0xDEADBEEF to 0x26 → mem_write high only in cycle 2, done in cycle 3. Then read 0x26 → rdata=0xDEADBEEF in DONE, mem_read high for exactly 1 cycle.
- Stretched access, WAIT_CYCLES=3: read 0x5F with RAM preloaded to 0xD → mem_read high for cycles 2–4, done in cycle 5, rdata=0xD.
- Ignored request: pulse req with address 0x33 during ACCESS → no second access occurs; mem_address stays at the first address; exactly one done pulse.
- Back-to-back requests: hold req=1 continuously with alternating we → one access every WAIT_CYCLES+3 cycles; strobes never overlap; a write leaves rdata unchanged.
- Bounds, macro defined: read 0x200 → no strobe, done 1 cycle after acceptance, err=1, rdata unchanged; a following read of 0x1 clears err. With the macro undefined, the same read of 0x200 produces mem_read high and err stays 0.
